// File: rtl/disparo_aliado.sv
// Player projectile controller: fire edge capture, per-frame upward flight,
// enemy hit test, growing-radius explosion and reload cooldown.
module disparo_aliado #(
  parameter int VELOCIDADE      = 8,
  parameter int RAIO            = 4,
  parameter int RAIO_MAX        = 12,
  parameter int RECARGA_QUADROS = 10,
  parameter int NAVE_LARGURA    = 45,
  parameter int INIMIGO_LARGURA = 33,
  parameter int INIMIGO_ALTURA  = 24
) (
  input  logic       VGA_CLK,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       ativo,
  input  logic       perdeu,
  input  logic       disparo,
  input  logic [9:0] x_nave,
  input  logic [9:0] y_nave,
  input  logic [9:0] x_inimigo,
  input  logic [9:0] y_inimigo,
  input  logic       inimigo_vivo,
  output logic [9:0] x_bola_aliada,
  output logic [9:0] y_bola_aliada,
  output logic [9:0] raio_bola_aliada,
  output logic       bola_ativa,
  output logic       acerto,
  output logic [1:0] estado
);

  typedef enum logic [1:0] {
    OCIOSO     = 2'd0,
    VOANDO     = 2'd1,
    EXPLODINDO = 2'd2,
    RECARGA    = 2'd3
  } estado_t;

  estado_t    state;
  logic       pending;
  logic       disparo_d;
  logic [7:0] cooldown;

  logic       fire_edge;
  logic       fora_tela;
  logic       hit;
  logic [9:0] y_novo;

  assign estado    = state;
  assign fire_edge = disparo & ~disparo_d;
  assign y_novo    = y_bola_aliada - 10'(VELOCIDADE);

  // Checked before the move, so y_novo cannot underflow when it is used.
  assign fora_tela = {1'b0, y_bola_aliada} < 11'(VELOCIDADE + RAIO);

  // Hitbox bounds widened to 11 bits so enemies near the right/bottom edge never wrap.
  assign hit = inimigo_vivo
             && ({1'b0, x_bola_aliada} >= {1'b0, x_inimigo})
             && ({1'b0, x_bola_aliada} <  ({1'b0, x_inimigo} + 11'(INIMIGO_LARGURA)))
             && ({1'b0, y_novo} >= {1'b0, y_inimigo})
             && ({1'b0, y_novo} <  ({1'b0, y_inimigo} + 11'(INIMIGO_ALTURA)));

  always_ff @(posedge VGA_CLK or posedge reset) begin
    if (reset) begin
      state            <= OCIOSO;
      pending          <= 1'b0;
      disparo_d        <= 1'b0;
      cooldown         <= 8'd0;
      x_bola_aliada    <= 10'd0;
      y_bola_aliada    <= 10'd0;
      raio_bola_aliada <= 10'd0;
      bola_ativa       <= 1'b0;
      acerto           <= 1'b0;
    end else begin
      disparo_d <= disparo;
      acerto    <= 1'b0;
      if (!ativo || perdeu) begin
        state            <= OCIOSO;
        pending          <= 1'b0;
        raio_bola_aliada <= 10'd0;
        bola_ativa       <= 1'b0;
      end else begin
        case (state)
          OCIOSO: begin
            if (frame_tick && (pending || fire_edge)) begin
              pending <= 1'b0;
              if ({1'b0, y_nave} < 11'(RAIO)) begin
                // Ship too close to the top to spawn: the shot is spent anyway.
                cooldown <= 8'(RECARGA_QUADROS);
                state    <= RECARGA;
              end else begin
                x_bola_aliada    <= x_nave + 10'(NAVE_LARGURA / 2);
                y_bola_aliada    <= y_nave - 10'(RAIO);
                raio_bola_aliada <= 10'(RAIO);
                bola_ativa       <= 1'b1;
                state            <= VOANDO;
              end
            end else if (fire_edge) begin
              pending <= 1'b1;
            end
          end
          VOANDO: begin
            if (frame_tick) begin
              if (fora_tela) begin
                raio_bola_aliada <= 10'd0;
                bola_ativa       <= 1'b0;
                cooldown         <= 8'(RECARGA_QUADROS);
                state            <= RECARGA;
              end else begin
                y_bola_aliada <= y_novo;
                if (hit) begin
                  acerto <= 1'b1;
                  state  <= EXPLODINDO;
                end
              end
            end
          end
          EXPLODINDO: begin
            if (frame_tick) begin
              if (raio_bola_aliada == 10'(RAIO_MAX)) begin
                raio_bola_aliada <= 10'd0;
                bola_ativa       <= 1'b0;
                cooldown         <= 8'(RECARGA_QUADROS);
                state            <= RECARGA;
              end else begin
                raio_bola_aliada <= raio_bola_aliada + 10'd1;
              end
            end
          end
          RECARGA: begin
            if (frame_tick) begin
              cooldown <= cooldown - 8'd1;
              if (cooldown <= 8'd1) state <= OCIOSO;
            end
          end
          default: state <= OCIOSO;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_disparo_aliado.sv
// Directed bench for disparo_aliado: spawn, top exit, hit/explosion, fire
// hold, game gating and asynchronous reset.
module tb_disparo_aliado;

  logic       VGA_CLK = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       ativo = 1'b0;
  logic       perdeu = 1'b0;
  logic       disparo = 1'b0;
  logic [9:0] x_nave = 10'd0;
  logic [9:0] y_nave = 10'd0;
  logic [9:0] x_inimigo = 10'd0;
  logic [9:0] y_inimigo = 10'd0;
  logic       inimigo_vivo = 1'b0;
  logic [9:0] x_bola_aliada;
  logic [9:0] y_bola_aliada;
  logic [9:0] raio_bola_aliada;
  logic       bola_ativa;
  logic       acerto;
  logic [1:0] estado;

  int errors = 0;
  int checks = 0;
  int acerto_count = 0;

  localparam logic [1:0] S_OCIOSO = 2'd0, S_VOANDO = 2'd1,
                         S_EXPLODINDO = 2'd2, S_RECARGA = 2'd3;

  disparo_aliado dut (
    .VGA_CLK(VGA_CLK), .reset(reset), .frame_tick(frame_tick), .ativo(ativo),
    .perdeu(perdeu), .disparo(disparo), .x_nave(x_nave), .y_nave(y_nave),
    .x_inimigo(x_inimigo), .y_inimigo(y_inimigo), .inimigo_vivo(inimigo_vivo),
    .x_bola_aliada(x_bola_aliada), .y_bola_aliada(y_bola_aliada),
    .raio_bola_aliada(raio_bola_aliada), .bola_ativa(bola_ativa),
    .acerto(acerto), .estado(estado)
  );

  // Clock and reset
  always #5 VGA_CLK = ~VGA_CLK;

  always @(posedge VGA_CLK) if (acerto === 1'b1) acerto_count++;

  // Driver tasks: all called and returning on a negedge
  task automatic cyc();
    @(negedge VGA_CLK);
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    @(negedge VGA_CLK);
    frame_tick = 1'b0;
  endtask

  task automatic fire_pulse();
    disparo = 1'b1;
    @(negedge VGA_CLK);
    disparo = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    frame_tick = 1'b0; perdeu = 1'b0; disparo = 1'b0;
    @(negedge VGA_CLK);
    reset = 1'b0;
    ativo = 1'b1;
    @(negedge VGA_CLK);
  endtask

  task automatic test_reset();
    @(negedge VGA_CLK);
    @(negedge VGA_CLK);
    checks++;
    if ({x_bola_aliada, y_bola_aliada, raio_bola_aliada, bola_ativa, acerto, estado} !== 34'd0) begin
      errors++;
      $display("FAIL reset_outputs: got x=%0d y=%0d r=%0d b=%0b a=%0b s=%0d required all 0",
               x_bola_aliada, y_bola_aliada, raio_bola_aliada, bola_ativa, acerto, estado);
    end
    reset = 1'b0;
  endtask

  task automatic test_spawn();
    do_reset();
    x_nave = 10'd300; y_nave = 10'd400; inimigo_vivo = 1'b0;
    fire_pulse();
    checks++;
    if (raio_bola_aliada !== 10'd0 || bola_ativa !== 1'b0) begin
      errors++;
      $display("FAIL spawn_wait_tick: got r=%0d b=%0b required r=0 b=0", raio_bola_aliada, bola_ativa);
    end
    tick();
    checks++;
    if (x_bola_aliada !== 10'd322 || y_bola_aliada !== 10'd396 || raio_bola_aliada !== 10'd4 ||
        bola_ativa !== 1'b1 || estado !== S_VOANDO) begin
      errors++;
      $display("FAIL spawn: got x=%0d y=%0d r=%0d b=%0b s=%0d required x=322 y=396 r=4 b=1 s=1",
               x_bola_aliada, y_bola_aliada, raio_bola_aliada, bola_ativa, estado);
    end
  endtask

  task automatic test_top_exit();
    do_reset();
    x_nave = 10'd300; y_nave = 10'd40; inimigo_vivo = 1'b0;
    fire_pulse();
    tick();
    checks++;
    if (y_bola_aliada !== 10'd36) begin
      errors++; $display("FAIL exit_spawn_y: got %0d required 36", y_bola_aliada);
    end
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if (y_bola_aliada !== 10'(36 - 8 * k) || raio_bola_aliada !== 10'd4) begin
        errors++;
        $display("FAIL exit_move_%0d: got y=%0d r=%0d required y=%0d r=4", k, y_bola_aliada, raio_bola_aliada, 36 - 8 * k);
      end
    end
    tick();
    checks++;
    if (raio_bola_aliada !== 10'd0 || bola_ativa !== 1'b0 || estado !== S_RECARGA) begin
      errors++;
      $display("FAIL exit_offscreen: got r=%0d b=%0b s=%0d required r=0 b=0 s=3", raio_bola_aliada, bola_ativa, estado);
    end
    fire_pulse();
    for (int k = 0; k < 9; k++) tick();
    checks++;
    if (estado !== S_RECARGA) begin
      errors++; $display("FAIL cooldown_9: got s=%0d required s=3", estado);
    end
    tick();
    checks++;
    if (estado !== S_OCIOSO) begin
      errors++; $display("FAIL cooldown_10: got s=%0d required s=0", estado);
    end
    tick();
    checks++;
    if (raio_bola_aliada !== 10'd0 || estado !== S_OCIOSO) begin
      errors++; $display("FAIL recarga_press_dropped: got r=%0d s=%0d required r=0 s=0", raio_bola_aliada, estado);
    end
    fire_pulse();
    tick();
    checks++;
    if (raio_bola_aliada !== 10'd4 || y_bola_aliada !== 10'd36 || estado !== S_VOANDO) begin
      errors++;
      $display("FAIL refire: got r=%0d y=%0d s=%0d required r=4 y=36 s=1", raio_bola_aliada, y_bola_aliada, estado);
    end
  endtask

  task automatic test_hit();
    int base;
    do_reset();
    base = acerto_count;
    x_nave = 10'd300; y_nave = 10'd400;
    x_inimigo = 10'd310; y_inimigo = 10'd300; inimigo_vivo = 1'b1;
    fire_pulse();
    tick();
    for (int k = 1; k <= 9; k++) begin
      tick();
      checks++;
      if (y_bola_aliada !== 10'(396 - 8 * k) || acerto !== 1'b0 || estado !== S_VOANDO) begin
        errors++;
        $display("FAIL hit_approach_%0d: got y=%0d a=%0b s=%0d required y=%0d a=0 s=1",
                 k, y_bola_aliada, acerto, estado, 396 - 8 * k);
      end
    end
    tick();
    checks++;
    if (y_bola_aliada !== 10'd316 || acerto !== 1'b1 || estado !== S_EXPLODINDO || raio_bola_aliada !== 10'd4) begin
      errors++;
      $display("FAIL hit_pulse: got y=%0d a=%0b s=%0d r=%0d required y=316 a=1 s=2 r=4",
               y_bola_aliada, acerto, estado, raio_bola_aliada);
    end
    cyc();
    checks++;
    if (acerto !== 1'b0 || acerto_count - base !== 1) begin
      errors++;
      $display("FAIL hit_one_cycle: got a=%0b pulses=%0d required a=0 pulses=1", acerto, acerto_count - base);
    end
    for (int k = 5; k <= 12; k++) begin
      tick();
      checks++;
      if (raio_bola_aliada !== 10'(k) || y_bola_aliada !== 10'd316 || x_bola_aliada !== 10'd322 || bola_ativa !== 1'b1) begin
        errors++;
        $display("FAIL explode_r%0d: got r=%0d x=%0d y=%0d b=%0b required r=%0d x=322 y=316 b=1",
                 k, raio_bola_aliada, x_bola_aliada, y_bola_aliada, bola_ativa, k);
      end
    end
    tick();
    checks++;
    if (raio_bola_aliada !== 10'd0 || bola_ativa !== 1'b0 || estado !== S_RECARGA) begin
      errors++;
      $display("FAIL explode_end: got r=%0d b=%0b s=%0d required r=0 b=0 s=3", raio_bola_aliada, bola_ativa, estado);
    end
    for (int k = 0; k < 9; k++) tick();
    checks++;
    if (estado !== S_RECARGA) begin
      errors++; $display("FAIL hit_cooldown_9: got s=%0d required s=3", estado);
    end
    tick();
    checks++;
    if (estado !== S_OCIOSO || acerto_count - base !== 1) begin
      errors++;
      $display("FAIL hit_cooldown_10: got s=%0d pulses=%0d required s=0 pulses=1", estado, acerto_count - base);
    end
  endtask

  task automatic test_no_enemy();
    int n;
    int base;
    do_reset();
    base = acerto_count;
    x_nave = 10'd300; y_nave = 10'd400;
    x_inimigo = 10'd310; y_inimigo = 10'd300; inimigo_vivo = 1'b0;
    fire_pulse();
    tick();
    n = 0;
    while (bola_ativa === 1'b1 && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 50 || acerto_count - base !== 0 || estado !== S_RECARGA) begin
      errors++;
      $display("FAIL no_enemy_exit: got ticks=%0d pulses=%0d s=%0d required ticks=50 pulses=0 s=3",
               n, acerto_count - base, estado);
    end
  endtask

  task automatic test_back_to_back_hold();
    do_reset();
    x_nave = 10'd300; y_nave = 10'd40; inimigo_vivo = 1'b0;
    disparo = 1'b1;
    tick();
    checks++;
    if (raio_bola_aliada !== 10'd4 || y_bola_aliada !== 10'd36) begin
      errors++;
      $display("FAIL same_cycle_fire: got r=%0d y=%0d required r=4 y=36", raio_bola_aliada, y_bola_aliada);
    end
    for (int k = 0; k < 15; k++) tick();
    checks++;
    if (estado !== S_OCIOSO) begin
      errors++; $display("FAIL hold_back_idle: got s=%0d required s=0", estado);
    end
    for (int k = 0; k < 3; k++) tick();
    checks++;
    if (raio_bola_aliada !== 10'd0 || estado !== S_OCIOSO) begin
      errors++; $display("FAIL hold_no_refire: got r=%0d s=%0d required r=0 s=0", raio_bola_aliada, estado);
    end
    disparo = 1'b0;
    cyc();
    fire_pulse();
    tick();
    checks++;
    if (raio_bola_aliada !== 10'd4 || estado !== S_VOANDO) begin
      errors++; $display("FAIL release_refire: got r=%0d s=%0d required r=4 s=1", raio_bola_aliada, estado);
    end
  endtask

  task automatic test_spawn_discard();
    do_reset();
    x_nave = 10'd100; y_nave = 10'd2;
    fire_pulse();
    tick();
    checks++;
    if (raio_bola_aliada !== 10'd0 || bola_ativa !== 1'b0 || estado !== S_RECARGA) begin
      errors++;
      $display("FAIL spawn_discard: got r=%0d b=%0b s=%0d required r=0 b=0 s=3", raio_bola_aliada, bola_ativa, estado);
    end
  endtask

  task automatic test_gating();
    do_reset();
    x_nave = 10'd300; y_nave = 10'd400; inimigo_vivo = 1'b0;
    fire_pulse();
    tick();
    for (int k = 0; k < 3; k++) tick();
    perdeu = 1'b1;
    cyc();
    perdeu = 1'b0;
    checks++;
    if (raio_bola_aliada !== 10'd0 || bola_ativa !== 1'b0 || acerto !== 1'b0 || estado !== S_OCIOSO ||
        y_bola_aliada !== 10'd372 || x_bola_aliada !== 10'd322) begin
      errors++;
      $display("FAIL perdeu_gate: got r=%0d b=%0b a=%0b s=%0d x=%0d y=%0d required r=0 b=0 a=0 s=0 x=322 y=372",
               raio_bola_aliada, bola_ativa, acerto, estado, x_bola_aliada, y_bola_aliada);
    end
    fire_pulse();
    ativo = 1'b0;
    cyc();
    ativo = 1'b1;
    tick();
    checks++;
    if (raio_bola_aliada !== 10'd0 || estado !== S_OCIOSO) begin
      errors++; $display("FAIL ativo_clears_pending: got r=%0d s=%0d required r=0 s=0", raio_bola_aliada, estado);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    x_nave = 10'd300; y_nave = 10'd400;
    fire_pulse();
    tick();
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({x_bola_aliada, y_bola_aliada, raio_bola_aliada, bola_ativa, acerto, estado} !== 34'd0) begin
      errors++;
      $display("FAIL async_reset: got x=%0d y=%0d r=%0d b=%0b s=%0d required all 0",
               x_bola_aliada, y_bola_aliada, raio_bola_aliada, bola_ativa, estado);
    end
    @(negedge VGA_CLK);
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_spawn();
    test_top_exit();
    test_hit();
    test_no_enemy();
    test_back_to_back_hold();
    test_spawn_discard();
    test_gating();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/disparo_aliado.md
Name: disparo_aliado

Overview:
- Controls the player's projectile ("bola aliada") in active-area pixel coordinates, one update per video frame.
- Registers fire requests, spawns the ball at the ship's nose and moves it upward each frame.
- Tests for an enemy hit, then runs a growing-radius explosion and a reload cooldown.
- Sits directly upstream of the screen renderer: drives its x_bola_aliada, y_bola_aliada and raio_bola_aliada inputs, and feeds an `acerto` pulse to the enemy/score logic.

Parameters:
- VELOCIDADE, 8: pixels moved upward per frame.
- RAIO, 4: in-flight ball radius.
- RAIO_MAX, 12: final explosion radius.
- RECARGA_QUADROS, 10: frames of cooldown before the next shot.
- NAVE_LARGURA, 45: ship sprite width (15 px × 3).
- INIMIGO_LARGURA, 33: enemy hitbox width (11 × 3).
- INIMIGO_ALTURA, 24: enemy hitbox height (8 × 3).

Ports:
- VGA_CLK  in  1  pixel clock
- reset  in  1  asynchronous, active-high
- frame_tick  in  1  one-cycle pulse per frame, asserted during vertical blank
- ativo  in  1  game running
- perdeu  in  1  game over
- disparo  in  1  fire button, debounced, level
- x_nave  in  10  ship top-left X
- y_nave  in  10  ship top-left Y
- x_inimigo  in  10  enemy top-left X
- y_inimigo  in  10  enemy top-left Y
- inimigo_vivo  in  1  enemy present
- x_bola_aliada  out  10  ball centre X
- y_bola_aliada  out  10  ball centre Y
- raio_bola_aliada  out  10  ball radius; 0 = not drawn
- bola_ativa  out  1  high in VOANDO or EXPLODINDO
- acerto  out  1  one-cycle hit pulse

Behaviour:
- Clock and reset: clock VGA_CLK; reset is asynchronous, active-high.
- Reset values: all outputs 0, state OCIOSO, pending = 0, disparo_d = 0, cooldown counter 0.
- All outputs are registered. Position, radius and state change only on the VGA_CLK edge where frame_tick = 1; outputs reflect the update one cycle later.
- Fire detection:
  - disparo_d holds the previous disparo sample.
  - A rising edge (disparo & ~disparo_d) in OCIOSO sets pending.
  - Edges in any other state are ignored and do not set pending.
  - Holding the button never re-fires.
- Game gating: ativo = 0 or perdeu = 1 forces, on the next edge regardless of frame_tick, state OCIOSO, pending 0, raio 0, bola_ativa 0, acerto 0. Coordinates hold their last values.
- OCIOSO, on frame_tick with pending = 1:
  - x ← x_nave + NAVE_LARGURA/2 (integer, i.e. +22), y ← y_nave − RAIO, raio ← RAIO.
  - pending ← 0; go to VOANDO.
  - If y_nave < RAIO, the spawn is discarded; go to RECARGA instead.
- VOANDO, on frame_tick:
  - If y < VELOCIDADE + RAIO: off-screen. raio ← 0, cooldown ← RECARGA_QUADROS, go to RECARGA.
  - Otherwise y ← y − VELOCIDADE, then hit-test on the new y.
  - Hit condition: inimigo_vivo & x ≥ x_inimigo & x < x_inimigo + INIMIGO_LARGURA & y ≥ y_inimigo & y < y_inimigo + INIMIGO_ALTURA.
  - Comparisons use 11-bit unsigned sums; no wrap.
  - On hit: acerto = 1 for exactly one cycle, go to EXPLODINDO with position frozen.
  - The off-screen check has priority over the hit test.
- EXPLODINDO, on frame_tick:
  - raio ← raio + 1.
  - On the tick where raio is already RAIO_MAX: raio ← 0, cooldown ← RECARGA_QUADROS, go to RECARGA.
  - The radius therefore runs RAIO+1 … RAIO_MAX, one value per frame.
- RECARGA, on frame_tick:
  - cooldown decrements.
  - On the tick it reads 1: go to OCIOSO.
  - Fire edges during RECARGA are dropped.
- Simultaneous events: a disparo edge in the same cycle as frame_tick while in OCIOSO counts as pending for that tick (fires immediately).
- acerto is never high outside the VOANDO→EXPLODINDO transition cycle.

Test Plan:
- Spawn: reset; ativo = 1; x_nave = 300, y_nave = 400; pulse disparo; frame_tick → next cycle x = 322, y = 396, raio = 4, bola_ativa = 1.
- Top exit: y_nave = 40; fire → y = 36; ticks give 28, 20, 12, 4; next tick → raio = 0, bola_ativa = 0, state RECARGA. After 10 ticks a new fire is accepted.
- Hit: ship at (300, 400), enemy at (310, 300) with inimigo_vivo = 1; fire; 10th move tick gives y = 316 → acerto high for exactly 1 cycle. Then raio = 5, 6, …, 12 on 8 ticks, raio = 0 on the 9th tick, then 10 cooldown ticks.
- Same geometry with inimigo_vivo = 0 → no acerto; ball exits at top.
- Hold disparo high through the whole flight and cooldown → exactly one shot. A press during RECARGA is ignored; a press after return to OCIOSO fires on the next tick.
- Mid-flight perdeu = 1 → next cycle raio = 0, bola_ativa = 0, no acerto. Async reset asserted between clock edges → all outputs 0 immediately.
